display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 17, prescaler width; one digit slot lasts 2^DIV_WIDTH clk cycles.
REQ-002 Port clk  input  1  system clock; all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port en  input  1  scan enable; low freezes all state.
REQ-005 Port digits_in  input  16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3.
REQ-006 Port dp_in  input  4  decimal points, bit n = digit n, active-high.
REQ-007 Port refresh_counter  output  2  active digit index, feeds downstream anode selection.
REQ-008 Port seg  output  7  cathodes, active-low, bit0=a ... bit6=g.
REQ-009 Port dp  output  1  decimal-point cathode, active-low.
REQ-010 Port frame_tick  output  1  one-cycle pulse at start of each frame.

Function
REQ-011 Prescaler: DIV_WIDTH-bit counter; +1 per clk while en=1; holds while en=0.
REQ-012 Slot tick: prescaler all-ones with en=1; prescaler wraps to 0 on that edge.
REQ-013 On slot tick, refresh_counter increments mod 4 (3->0 wrap); otherwise holds.
REQ-014 Frame boundary: edge where refresh_counter goes 3->0; on that edge digits_in and dp_in load into shadow registers.
REQ-015 frame_tick: registered, high exactly one cycle, in the first cycle refresh_counter reads 0 after a 3->0 wrap; never high after reset until the first wrap.
REQ-016 seg/dp: combinational from refresh_counter and shadow registers; valid in the same cycle as refresh_counter, no extra latency.
REQ-017 Input-to-display latency: change on digits_in appears from the next frame boundary, worst case 4*2^DIV_WIDTH cycles; mid-frame input changes never alter the current frame (no tearing).
REQ-018 Segment code: 0-9 standard patterns (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000); codes 10-15 -> blank 7'b1111111.
REQ-019 dp = ~shadow_dp[refresh_counter].
REQ-020 Slot tick and en falling in the same cycle: en sampled low wins; no increment.

Reset
REQ-021 rst_n low: prescaler, refresh_counter, shadow digits, shadow dp and frame_tick clear immediately, independent of clk.
REQ-022 Outputs during/after reset: refresh_counter=0, seg=7'b1000000, dp=1, frame_tick=0.
REQ-023 Reset mid-frame: scan restarts at digit 0 with a full slot; shadow contents discarded.

Configuration
REQ-024 Macro SCAN_LZB_EN defined: leading-zero blanking; digit3 blanked if 0; digit2 if digits 3..2 are 0; digit1 if digits 3..1 are 0; digit0 never blanked; blanked digit drives seg=7'b1111111 and dp=1.
REQ-025 SCAN_LZB_EN undefined: all four digits always decoded per REQ-018/019; no blanking logic present.

Structure
REQ-026 Shared package disp_pkg holds NUM_DIGITS=4, SEG_BLANK=7'b1111111, digit-index type (2 bits), the ten segment constants.
REQ-027 One sub-module seg7_decode: combinational 4-bit BCD -> 7-bit active-low seg, blank for 10-15; instantiated once on the muxed digit.

Verification (DIV_WIDTH=2 for simulation)
REQ-028 Reset release, en=1, digits_in=16'h1234 -> refresh_counter 0,1,2,3,0 every 4 clks; first frame shows 0,0,0,0; from first wrap seg shows 4,3,2,1 for idx 0..3; frame_tick one pulse per 16 clks.
REQ-029 digits_in 16'h1234->16'h5678 at idx 1 mid-slot -> idx 2,3 still show 2,1; after next wrap show 8,7,6,5.
REQ-030 en=0 for 10 clks at idx 2 -> refresh_counter, seg, frame_tick frozen; resume completes remaining slot cycles exactly.
REQ-031 digits_in=16'h00AF, dp_in=4'b0100 -> idx0 and idx1 seg=7'b1111111 (invalid codes); idx2 dp=0; with SCAN_LZB_EN idx2,idx3 seg=7'b1111111, dp=1; without it both show 0.
REQ-032 rst_n pulsed low asynchronously at idx 3 -> outputs reach REQ-022 values before next clk edge; scan resumes at idx 0 with shadow=0.

Source files
------------

// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg -- shared constants and types for the display scan controller. Rev 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Active-low cathodes, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode -- BCD to active-low 7-segment decoder, codes 10-15 blank. Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl -- 4-digit multiplexed 7-segment scanner with frame-latched
// shadow registers; optional leading-zero blanking via SCAN_LZB_EN. Rev 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV_WIDTH = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [1:0]  refresh_counter,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
  digit_idx_t           idx_q, idx_d;
  logic [15:0]          shadow_dig_q, shadow_dig_d;
  logic [3:0]           shadow_dp_q, shadow_dp_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 w_slot_tick;
  logic                 w_frame_wrap;
  logic [3:0]           w_digit;
  logic [6:0]           w_seg_raw;

  always_comb begin
    w_slot_tick  = en & (&prescaler_q);
    w_frame_wrap = w_slot_tick & (idx_q == digit_idx_t'(NUM_DIGITS - 1));

    prescaler_d  = prescaler_q;
    idx_d        = idx_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    frame_tick_d = w_frame_wrap;

    if (en) begin
      prescaler_d = prescaler_q + DIV_WIDTH'(1);
    end
    if (w_slot_tick) begin
      idx_d = idx_q + 2'd1;
    end
    // Inputs are sampled only at the frame boundary so a frame never tears.
    if (w_frame_wrap) begin
      shadow_dig_d = digits_in;
      shadow_dp_d  = dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign w_digit = shadow_dig_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .bcd_i (w_digit),
    .seg_o (w_seg_raw)
  );

`ifdef SCAN_LZB_EN
  logic w_blank;

  always_comb begin
    w_blank = 1'b0;
    case (idx_q)
      2'd3:    w_blank = (shadow_dig_q[15:12] == 4'd0);
      2'd2:    w_blank = (shadow_dig_q[15:8]  == 8'd0);
      2'd1:    w_blank = (shadow_dig_q[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end

  assign seg = w_blank ? SEG_BLANK : w_seg_raw;
  assign dp  = w_blank ? 1'b1 : ~shadow_dp_q[idx_q];
`else
  assign seg = w_seg_raw;
  assign dp  = ~shadow_dp_q[idx_q];
`endif

  assign refresh_counter = idx_q;
  assign frame_tick      = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// tb_display_scan_ctrl -- scoreboard bench for display_scan_ctrl (DIV_WIDTH=2).
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

  localparam int DW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [1:0]  refresh_counter;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  display_scan_ctrl #(.DIV_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .digits_in       (digits_in),
    .dp_in           (dp_in),
    .refresh_counter (refresh_counter),
    .seg             (seg),
    .dp              (dp),
    .frame_tick      (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event async_chk;

  // Reference model state
  int          m_pre = 0;
  int          m_idx = 0;
  logic [15:0] m_dig = 16'h0000;
  logic [3:0]  m_dp  = 4'h0;
  logic        m_ft  = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t make_exp();
    exp_t       e;
    logic [3:0] d;
    d     = m_dig[m_idx*4 +: 4];
    e.idx = m_idx[1:0];
    e.seg = ref_seg(d);
    e.dp  = ~m_dp[m_idx];
    e.ft  = m_ft;
`ifdef SCAN_LZB_EN
    if ((m_idx == 3 && m_dig[15:12] == 4'd0) ||
        (m_idx == 2 && m_dig[15:8]  == 8'd0) ||
        (m_idx == 1 && m_dig[15:4]  == 12'd0)) begin
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic push_exp();
    sb_q.push_back(make_exp());
  endtask

  task automatic model_reset();
    m_pre = 0;
    m_idx = 0;
    m_dig = 16'h0000;
    m_dp  = 4'h0;
    m_ft  = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, queue expectation.
  task automatic cyc();
    @(posedge clk);
    #1;
    m_ft = 1'b0;
    if (rst_n && en) begin
      if (m_pre == (1 << DW) - 1) begin
        m_pre = 0;
        if (m_idx == 3) begin
          m_ft  = 1'b1;
          m_dig = digits_in;
          m_dp  = dp_in;
        end
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    push_exp();
  endtask

  task automatic run_until(input int idx, input int pre);
    int k;
    k = 0;
    while (!(m_idx == idx && m_pre == pre) && k < 64) begin
      cyc();
      k++;
    end
    if (k >= 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_until timeout: got idx=%0d pre=%0d required idx=%0d pre=%0d",
               m_idx, m_pre, idx, pre);
    end
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, got, exp);
    end
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk or async_chk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("refresh_counter", {5'd0, refresh_counter}, {5'd0, e.idx});
      check("seg",             seg,                     e.seg);
      check("dp",              {6'd0, dp},              {6'd0, e.dp});
      check("frame_tick",      {6'd0, frame_tick},      {6'd0, e.ft});
    end
  end

  initial begin
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    en        = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    push_exp();
    -> async_chk;

    // Reset release, first frame blank-zero, then 4,3,2,1
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (36) cyc();

    // Mid-frame input change does not tear the current frame
    run_until(1, 1);
    digits_in = 16'h5678;
    repeat (28) cyc();

    // Enable held low mid-slot freezes everything
    run_until(2, 1);
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (20) cyc();

    // Invalid codes and decimal point handling
    digits_in = 16'h00AF;
    dp_in     = 4'b0100;
    repeat (36) cyc();

    // Asynchronous reset at digit 3, mid-slot
    run_until(3, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp();
    -> async_chk;
    @(posedge clk);
    #1;
    push_exp();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (24) cyc();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
